// File: rtl/mem_responder.sv
// Single-ported 32-bit word RAM shared by an instruction-fetch port and a data
// load/store port, with per-cycle arbitration and a fixed one-cycle response.
module mem_responder #(
    parameter int    AW        = 12,
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [AW-1:0] i_addr,
    output logic          i_rsp_valid,
    output logic [31:0]   i_rsp_data,
    output logic          i_rsp_err,

    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [3:0]    d_wstrb,
    input  logic [31:0]   d_wdata,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rsp_data,
    output logic          d_rsp_err
);

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic {PRIO_D = 1'b0, PRIO_I = 1'b1} prio_t;

    prio_t          prio_q;
    logic           grant_i;
    logic           grant_d;
    logic           conflict;
    logic [AW-1:0]  acc_addr;
    logic           acc_hit;
    logic [IW-1:0]  acc_idx;
    logic           acc_wr;

    logic [31:0]    mem [DEPTH];
    logic [31:0]    ram_q;

    logic           i_vld_q;
    logic           i_err_q;
    logic [31:0]    i_hold_q;
    logic           d_vld_q;
    logic           d_err_q;
    logic [31:0]    d_hold_q;

    // Handshake: a request transfers on a cycle where valid && ready; ready is
    // combinational from both valids and prio, never high for an idle port or
    // during reset, and at most one port sees ready in any cycle. The response
    // appears exactly one cycle later and cannot be stalled.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (i_req_valid && d_req_valid) begin
                grant_d = (prio_q == PRIO_D);
                grant_i = (prio_q == PRIO_I);
            end else begin
                grant_i = i_req_valid;
                grant_d = d_req_valid;
            end
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign conflict    = !reset && i_req_valid && d_req_valid;

    // Full-width compare so addresses beyond DEPTH never alias into the array.
    assign acc_addr = grant_d ? d_addr : i_addr;
    assign acc_hit  = ({1'b0, acc_addr} < DEPTH_W);
    assign acc_idx  = acc_addr[IW-1:0];
    assign acc_wr   = grant_d && d_we && acc_hit;

    // Read-first port: ram_q captures the word before any byte-masked write.
    always_ff @(posedge clk) begin
        if ((grant_i || grant_d) && acc_hit) begin
            ram_q <= mem[acc_idx];
            if (acc_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (d_wstrb[b]) begin
                        mem[acc_idx][8*b +: 8] <= d_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= PRIO_D;
            i_vld_q  <= 1'b0;
            i_err_q  <= 1'b0;
            i_hold_q <= '0;
            d_vld_q  <= 1'b0;
            d_err_q  <= 1'b0;
            d_hold_q <= '0;
        end else begin
            i_vld_q <= grant_i;
            i_err_q <= grant_i && !acc_hit;
            d_vld_q <= grant_d;
            d_err_q <= grant_d && !acc_hit;
            if (i_vld_q) begin
                i_hold_q <= i_rsp_data;
            end
            if (d_vld_q) begin
                d_hold_q <= d_rsp_data;
            end
            if (conflict) begin
                prio_q <= (prio_q == PRIO_D) ? PRIO_I : PRIO_D;
            end
        end
    end

    // Gating with reset drops a response that falls due while reset is high.
    assign i_rsp_valid = i_vld_q && !reset;
    assign i_rsp_err   = i_err_q && !reset;
    assign i_rsp_data  = reset   ? '0 :
                         i_vld_q ? (i_err_q ? '0 : ram_q) : i_hold_q;

    assign d_rsp_valid = d_vld_q && !reset;
    assign d_rsp_err   = d_err_q && !reset;
    assign d_rsp_data  = reset   ? '0 :
                         d_vld_q ? (d_err_q ? '0 : ram_q) : d_hold_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: arbitration, read-first stores, range
// errors, back-to-back loads and reset behaviour, checked with immediate asserts.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [11:0] i_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [11:0] d_addr;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;

    int total = 0;
    int bad   = 0;

    mem_responder #(
        .AW(12),
        .DEPTH(3000),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req_valid(i_req_valid),
        .i_req_ready(i_req_ready),
        .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid),
        .i_rsp_data(i_rsp_data),
        .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid),
        .d_req_ready(d_req_ready),
        .d_addr(d_addr),
        .d_we(d_we),
        .d_wstrb(d_wstrb),
        .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_data(d_rsp_data),
        .d_rsp_err(d_rsp_err)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] w(input int k);
        return (k == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(k));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drv(input logic iv, input logic [11:0] ia, input logic dv,
                       input logic [11:0] da, input logic we, input logic [3:0] st,
                       input logic [31:0] wd);
        i_req_valid = iv;
        i_addr      = ia;
        d_req_valid = dv;
        d_addr      = da;
        d_we        = we;
        d_wstrb     = st;
        d_wdata     = wd;
    endtask

    task automatic idle();
        drv(1'b0, 12'd0, 1'b0, 12'd0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, with both ports requesting
        reset = 1'b1;
        drv(1'b1, 12'd5, 1'b1, 12'd0, 1'b0, 4'h0, 32'h0);
        #1;
        settle();
        chk("rst_irdy", 32'(i_req_ready), 0);
        chk("rst_drdy", 32'(d_req_ready), 0);
        chk("rst_ivld", 32'(i_rsp_valid), 0);
        chk("rst_dvld", 32'(d_rsp_valid), 0);
        chk("rst_ddata", d_rsp_data, 0);
        nxt();
        settle();
        chk("rst2_irdy", 32'(i_req_ready), 0);
        chk("rst2_idata", i_rsp_data, 0);
        chk("rst2_ierr", 32'(i_rsp_err), 0);
        reset = 1'b0;
        idle();
        nxt();
        settle();
        chk("post_ivld", 32'(i_rsp_valid), 0);
        chk("post_dvld", 32'(d_rsp_valid), 0);
        chk("post_idata", i_rsp_data, 0);
        chk("post_ddata", d_rsp_data, 0);
        nxt();

        // preload through the data port
        for (int k = 0; k < 8; k++) begin
            drv(1'b0, 12'd0, 1'b1, 12'(k), 1'b1, 4'hF, w(k));
            settle();
            chk("pre_rdy", 32'(d_req_ready), 1);
            nxt();
        end
        drv(1'b0, 12'd0, 1'b1, 12'd10, 1'b1, 4'hF, 32'hAABBCCDD);
        settle();
        chk("pre_rdy10", 32'(d_req_ready), 1);
        nxt();
        drv(1'b0, 12'd0, 1'b1, 12'd1452, 1'b1, 4'hF, 32'h14521452);
        settle();
        chk("pre_rdy1452", 32'(d_req_ready), 1);
        nxt();
        idle();
        nxt();

        // single fetch of word 5
        drv(1'b1, 12'd5, 1'b0, 12'd0, 1'b0, 4'h0, 32'h0);
        settle();
        chk("f5_irdy", 32'(i_req_ready), 1);
        chk("f5_drdy", 32'(d_req_ready), 0);
        nxt();
        idle();
        settle();
        chk("f5_ivld", 32'(i_rsp_valid), 1);
        chk("f5_idata", i_rsp_data, 32'hDEADBEEF);
        chk("f5_ierr", 32'(i_rsp_err), 0);
        chk("f5_dvld", 32'(d_rsp_valid), 0);
        nxt();
        settle();
        chk("f5_hold_vld", 32'(i_rsp_valid), 0);
        chk("f5_hold_data", i_rsp_data, 32'hDEADBEEF);
        nxt();

        // back-to-back loads 0..7
        drv(1'b0, 12'd0, 1'b1, 12'd0, 1'b0, 4'h0, 32'h0);
        settle();
        chk("b2b_rdy0", 32'(d_req_ready), 1);
        nxt();
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) drv(1'b0, 12'd0, 1'b1, 12'(k), 1'b0, 4'h0, 32'h0);
            else       idle();
            settle();
            chk("b2b_dvld", 32'(d_rsp_valid), 1);
            chk("b2b_ddata", d_rsp_data, w(k - 1));
            nxt();
        end
        settle();
        chk("b2b_end_dvld", 32'(d_rsp_valid), 0);
        nxt();

        // byte-strobed store, read-first response, then read-after-write
        drv(1'b0, 12'd0, 1'b1, 12'd10, 1'b1, 4'b0101, 32'h11223344);
        settle();
        chk("st10_rdy", 32'(d_req_ready), 1);
        nxt();
        drv(1'b0, 12'd0, 1'b1, 12'd10, 1'b0, 4'h0, 32'h0);
        settle();
        chk("st10_dvld", 32'(d_rsp_valid), 1);
        chk("st10_old", d_rsp_data, 32'hAABBCCDD);
        chk("ld10_rdy", 32'(d_req_ready), 1);
        nxt();
        idle();
        settle();
        chk("ld10_data", d_rsp_data, 32'hAA22CC44);
        nxt();

        // four conflict cycles: D, I, D, I
        drv(1'b1, 12'd5, 1'b1, 12'd0, 1'b0, 4'h0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("arb_drdy", 32'(d_req_ready), 32'((c % 2) == 0));
            chk("arb_irdy", 32'(i_req_ready), 32'((c % 2) == 1));
            chk("arb_both", 32'(i_req_ready & d_req_ready), 0);
            chk("arb_dvld", 32'(d_rsp_valid), 32'((c > 0) && ((c - 1) % 2 == 0)));
            chk("arb_ivld", 32'(i_rsp_valid), 32'((c > 0) && ((c - 1) % 2 == 1)));
            if ((c > 0) && ((c - 1) % 2 == 0)) chk("arb_ddata", d_rsp_data, w(0));
            if ((c > 0) && ((c - 1) % 2 == 1)) chk("arb_idata", i_rsp_data, 32'hDEADBEEF);
            nxt();
        end
        idle();
        settle();
        chk("arb_last_ivld", 32'(i_rsp_valid), 1);
        chk("arb_last_idata", i_rsp_data, 32'hDEADBEEF);
        chk("arb_last_dvld", 32'(d_rsp_valid), 0);
        nxt();

        // out-of-range accesses (DEPTH = 3000)
        drv(1'b0, 12'd0, 1'b1, 12'd3500, 1'b0, 4'h0, 32'h0);
        settle();
        chk("oor_ld_rdy", 32'(d_req_ready), 1);
        nxt();
        drv(1'b0, 12'd0, 1'b1, 12'd3500, 1'b1, 4'hF, 32'hFFFFFFFF);
        settle();
        chk("oor_ld_vld", 32'(d_rsp_valid), 1);
        chk("oor_ld_err", 32'(d_rsp_err), 1);
        chk("oor_ld_data", d_rsp_data, 0);
        nxt();
        drv(1'b1, 12'd3000, 1'b0, 12'd0, 1'b0, 4'h0, 32'h0);
        settle();
        chk("oor_st_vld", 32'(d_rsp_valid), 1);
        chk("oor_st_err", 32'(d_rsp_err), 1);
        chk("oor_f_rdy", 32'(i_req_ready), 1);
        nxt();
        drv(1'b1, 12'd2999, 1'b0, 12'd0, 1'b0, 4'h0, 32'h0);
        settle();
        chk("oor_f3000_vld", 32'(i_rsp_valid), 1);
        chk("oor_f3000_err", 32'(i_rsp_err), 1);
        chk("oor_f3000_data", i_rsp_data, 0);
        nxt();
        drv(1'b0, 12'd0, 1'b1, 12'd1452, 1'b0, 4'h0, 32'h0);
        settle();
        chk("f2999_vld", 32'(i_rsp_valid), 1);
        chk("f2999_err", 32'(i_rsp_err), 0);
        nxt();
        idle();
        settle();
        chk("alias_vld", 32'(d_rsp_valid), 1);
        chk("alias_err", 32'(d_rsp_err), 0);
        chk("alias_data", d_rsp_data, 32'h14521452);
        nxt();

        // conflict moves prio to I, then a fetch is cut off by reset
        drv(1'b1, 12'd2, 1'b1, 12'd1, 1'b0, 4'h0, 32'h0);
        settle();
        chk("pr_drdy", 32'(d_req_ready), 1);
        chk("pr_irdy", 32'(i_req_ready), 0);
        nxt();
        drv(1'b1, 12'd5, 1'b0, 12'd0, 1'b0, 4'h0, 32'h0);
        settle();
        chk("rf_irdy", 32'(i_req_ready), 1);
        nxt();
        reset = 1'b1;
        drv(1'b1, 12'd5, 1'b1, 12'd0, 1'b0, 4'h0, 32'h0);
        settle();
        chk("rf_ivld", 32'(i_rsp_valid), 0);
        chk("rf_idata", i_rsp_data, 0);
        chk("rf_irdy_rst", 32'(i_req_ready), 0);
        chk("rf_drdy_rst", 32'(d_req_ready), 0);
        nxt();
        settle();
        chk("rf_ivld2", 32'(i_rsp_valid), 0);
        reset = 1'b0;
        #1;
        chk("rf_prio_d", 32'(d_req_ready), 1);
        chk("rf_prio_i", 32'(i_req_ready), 0);
        nxt();
        idle();
        settle();
        chk("rf_dvld", 32'(d_rsp_valid), 1);
        chk("rf_ddata", d_rsp_data, w(0));
        chk("rf_ivld3", 32'(i_rsp_valid), 0);
        nxt();

        // store accepted just before reset still commits
        drv(1'b0, 12'd0, 1'b1, 12'd6, 1'b1, 4'hF, 32'h66666666);
        settle();
        chk("sr_rdy", 32'(d_req_ready), 1);
        nxt();
        reset = 1'b1;
        idle();
        settle();
        chk("sr_dvld", 32'(d_rsp_valid), 0);
        nxt();
        reset = 1'b0;
        nxt();
        drv(1'b0, 12'd0, 1'b1, 12'd6, 1'b0, 4'h0, 32'h0);
        settle();
        chk("sr_ld_rdy", 32'(d_req_ready), 1);
        nxt();
        idle();
        settle();
        chk("sr_ld_vld", 32'(d_rsp_valid), 1);
        chk("sr_ld_data", d_rsp_data, 32'h66666666);
        nxt();

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
